// File: rtl/flag_status_unit.sv
// NZCV status register with writeback bypass and in-flight flag-writer tracking.
// Optional FLAG_SHADOW_EN adds a one-entry shadow for exception entry/return.
module flag_status_unit #(
  parameter int MAX_PENDING = 3,
  parameter int CNT_W       = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             issue_valid,
  input  logic             issue_s,
  input  logic [3:0]       cond_in,
  input  logic             wb_valid,
  input  logic             wb_s,
  input  logic [3:0]       wb_flags,
  input  logic             flush,
`ifdef FLAG_SHADOW_EN
  input  logic             save_req,
  input  logic             restore_req,
  output logic [3:0]       shadow_q,
`endif
  output logic [3:0]       flags_q,
  output logic [3:0]       flags_fwd,
  output logic [CNT_W-1:0] pending_cnt,
  output logic             issue_ready,
  output logic             flag_stall,
  output logic             err_sticky
);

  logic             wr;
  logic             dec;
  logic             inc;
  logic             needs_flags;
  logic [CNT_W-1:0] eff_cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             overflow;
  logic             underflow;
  logic [3:0]       wb_fwd;

  assign wr          = wb_valid & wb_s;
  assign dec         = wr;
  assign needs_flags = (cond_in[3:1] != 3'b111);

  // A committing writer with nothing counted is an underflow; it must not wrap
  // the effective count and spuriously stall decode.
  assign eff_cnt     = (dec && (pending_cnt != '0)) ? pending_cnt - 1'b1 : pending_cnt;
  assign issue_ready = (eff_cnt < CNT_W'(MAX_PENDING));
  assign flag_stall  = needs_flags & (eff_cnt != '0);
  assign inc         = issue_valid & issue_s & issue_ready & ~flag_stall;
  assign overflow    = issue_valid & issue_s & ~issue_ready;
  assign underflow   = dec & (pending_cnt == '0) & ~flush;
  assign wb_fwd      = wr ? wb_flags : flags_q;

`ifdef FLAG_SHADOW_EN
  assign flags_fwd = restore_req ? shadow_q : wb_fwd;
`else
  assign flags_fwd = wb_fwd;
`endif

  always_comb begin
    cnt_next = pending_cnt;
    if (flush)
      cnt_next = '0;
    else if (!underflow)
      cnt_next = pending_cnt + CNT_W'(inc) - CNT_W'(dec);
  end

  // flags_fwd already equals the value the register takes next.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q     <= 4'b0000;
      pending_cnt <= '0;
      err_sticky  <= 1'b0;
    end else begin
      flags_q     <= flags_fwd;
      pending_cnt <= cnt_next;
      if (overflow || underflow)
        err_sticky <= 1'b1;
    end
  end

`ifdef FLAG_SHADOW_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      shadow_q <= 4'b0000;
    else if (save_req)
      shadow_q <= wb_fwd;
  end
`endif

endmodule

// File: tb/tb_flag_status_unit.sv
// Table-driven bench for flag_status_unit with a queue-based scoreboard.
module tb_flag_status_unit;

  typedef struct {
    logic       rst;
    logic       iv;
    logic       is;
    logic [3:0] cond;
    logic       wv;
    logic       ws;
    logic [3:0] wf;
    logic       fl;
    logic       sv;
    logic       rs;
    logic [3:0] e_fwd;
    logic       e_stall;
    logic       e_ready;
    logic [3:0] e_q;
    logic [2:0] e_cnt;
    logic       e_err;
    logic [3:0] e_sh;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       issue_valid = 1'b0;
  logic       issue_s = 1'b0;
  logic [3:0] cond_in = 4'b1110;
  logic       wb_valid = 1'b0;
  logic       wb_s = 1'b0;
  logic [3:0] wb_flags = 4'b0000;
  logic       flush = 1'b0;
  logic       save_req = 1'b0;
  logic       restore_req = 1'b0;
  logic [3:0] shadow_q;
  logic [3:0] flags_q;
  logic [3:0] flags_fwd;
  logic [2:0] pending_cnt;
  logic       issue_ready;
  logic       flag_stall;
  logic       err_sticky;

  int n_vec  = 0;
  int n_miss = 0;
  vec_t vecs[$];
  vec_t sb[$];

  always #5 clk = ~clk;

  flag_status_unit #(.MAX_PENDING(3), .CNT_W(3)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .issue_valid (issue_valid),
    .issue_s     (issue_s),
    .cond_in     (cond_in),
    .wb_valid    (wb_valid),
    .wb_s        (wb_s),
    .wb_flags    (wb_flags),
    .flush       (flush),
`ifdef FLAG_SHADOW_EN
    .save_req    (save_req),
    .restore_req (restore_req),
    .shadow_q    (shadow_q),
`endif
    .flags_q     (flags_q),
    .flags_fwd   (flags_fwd),
    .pending_cnt (pending_cnt),
    .issue_ready (issue_ready),
    .flag_stall  (flag_stall),
    .err_sticky  (err_sticky)
  );

`ifndef FLAG_SHADOW_EN
  assign shadow_q = 4'b0000;
`endif

  task automatic chk(input string name, input int idx, input logic [3:0] got, input logic [3:0] exp);
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s vec %0d: got %b want %b", name, idx, got, exp);
    end
  endtask

  task automatic drive_idle();
    issue_valid = 1'b0; issue_s = 1'b0; cond_in = 4'b1110;
    wb_valid = 1'b0; wb_s = 1'b0; wb_flags = 4'b0000;
    flush = 1'b0; save_req = 1'b0; restore_req = 1'b0;
  endtask

  // Asynchronous reset: outputs must clear without any clock edge.
  task automatic do_reset(input int idx);
    drive_idle();
    rst_n = 1'b0;
    #2;
    chk("rst_flags_q", idx, flags_q, 4'b0000);
    chk("rst_cnt", idx, {1'b0, pending_cnt}, 4'd0);
    chk("rst_err", idx, {3'b0, err_sticky}, 4'd0);
    chk("rst_ready", idx, {3'b0, issue_ready}, 4'd1);
    chk("rst_stall", idx, {3'b0, flag_stall}, 4'd0);
    chk("rst_fwd", idx, flags_fwd, 4'b0000);
    chk("rst_shadow", idx, shadow_q, 4'b0000);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input int idx, input vec_t v);
    vec_t e;
    if (v.rst) do_reset(idx);
    issue_valid = v.iv; issue_s = v.is; cond_in = v.cond;
    wb_valid = v.wv; wb_s = v.ws; wb_flags = v.wf; flush = v.fl;
`ifdef FLAG_SHADOW_EN
    save_req = v.sv; restore_req = v.rs;
`endif
    sb.push_back(v);
    #4;
    e = sb[0];
    chk("fwd", idx, flags_fwd, e.e_fwd);
    chk("stall", idx, {3'b0, flag_stall}, {3'b0, e.e_stall});
    chk("ready", idx, {3'b0, issue_ready}, {3'b0, e.e_ready});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("flags_q", idx, flags_q, e.e_q);
    chk("cnt", idx, {1'b0, pending_cnt}, {1'b0, e.e_cnt});
    chk("err", idx, {3'b0, err_sticky}, {3'b0, e.e_err});
`ifdef FLAG_SHADOW_EN
    chk("shadow", idx, shadow_q, e.e_sh);
`endif
    $display("vec %0d: iv=%b is=%b cond=%b wr=%b%b/%b fl=%b -> q=%b cnt=%0d err=%b",
             idx, v.iv, v.is, v.cond, v.wv, v.ws, v.wf, v.fl, flags_q, pending_cnt, err_sticky);
    n_vec++;
  endtask

  initial begin
    // rst iv is cond     wv ws wf      fl sv rs | fwd     stl rdy q       cnt   err sh
    // Underflowing write straight after reset, bypassed the same cycle
    vecs.push_back('{1'b1,1'b0,1'b0,4'b1110,1'b1,1'b1,4'b0100,1'b0,1'b0,1'b0, 4'b0100,1'b0,1'b1,4'b0100,3'd0,1'b1,4'b0000});
    // Issue S, then EQ stalls, then resolves on a same-cycle writeback
    vecs.push_back('{1'b1,1'b1,1'b1,4'b1110,1'b0,1'b0,4'b0000,1'b0,1'b0,1'b0, 4'b0000,1'b0,1'b1,4'b0000,3'd1,1'b0,4'b0000});
    vecs.push_back('{1'b0,1'b0,1'b0,4'b0000,1'b0,1'b0,4'b0000,1'b0,1'b0,1'b0, 4'b0000,1'b1,1'b1,4'b0000,3'd1,1'b0,4'b0000});
    vecs.push_back('{1'b0,1'b0,1'b0,4'b0000,1'b1,1'b1,4'b0100,1'b0,1'b0,1'b0, 4'b0100,1'b0,1'b1,4'b0100,3'd0,1'b0,4'b0000});
    // Fill to MAX_PENDING; unconditional codes never stall
    vecs.push_back('{1'b0,1'b1,1'b1,4'b1110,1'b0,1'b0,4'b0000,1'b0,1'b0,1'b0, 4'b0100,1'b0,1'b1,4'b0100,3'd1,1'b0,4'b0000});
    vecs.push_back('{1'b0,1'b1,1'b1,4'b1111,1'b0,1'b0,4'b0000,1'b0,1'b0,1'b0, 4'b0100,1'b0,1'b1,4'b0100,3'd2,1'b0,4'b0000});
    vecs.push_back('{1'b0,1'b0,1'b0,4'b1110,1'b0,1'b0,4'b0000,1'b0,1'b0,1'b0, 4'b0100,1'b0,1'b1,4'b0100,3'd2,1'b0,4'b0000});
    vecs.push_back('{1'b0,1'b1,1'b1,4'b1110,1'b0,1'b0,4'b0000,1'b0,1'b0,1'b0, 4'b0100,1'b0,1'b1,4'b0100,3'd3,1'b0,4'b0000});
    // Overflow: fourth issue refused, sticky error set
    vecs.push_back('{1'b0,1'b1,1'b1,4'b1110,1'b0,1'b0,4'b0000,1'b0,1'b0,1'b0, 4'b0100,1'b0,1'b0,4'b0100,3'd3,1'b1,4'b0000});
    // Issue with same-cycle writeback while full: accepted, count holds
    vecs.push_back('{1'b0,1'b1,1'b1,4'b1110,1'b1,1'b1,4'b1001,1'b0,1'b0,1'b0, 4'b1001,1'b0,1'b1,4'b1001,3'd3,1'b1,4'b0000});
    vecs.push_back('{1'b0,1'b0,1'b0,4'b0001,1'b0,1'b0,4'b0000,1'b0,1'b0,1'b0, 4'b1001,1'b1,1'b0,4'b1001,3'd3,1'b1,4'b0000});
    // Mid-operation reset, then flush with writeback at count 2 (issue discarded)
    vecs.push_back('{1'b1,1'b1,1'b1,4'b1110,1'b0,1'b0,4'b0000,1'b0,1'b0,1'b0, 4'b0000,1'b0,1'b1,4'b0000,3'd1,1'b0,4'b0000});
    vecs.push_back('{1'b0,1'b1,1'b1,4'b1110,1'b0,1'b0,4'b0000,1'b0,1'b0,1'b0, 4'b0000,1'b0,1'b1,4'b0000,3'd2,1'b0,4'b0000});
    vecs.push_back('{1'b0,1'b1,1'b1,4'b1110,1'b1,1'b1,4'b0011,1'b1,1'b0,1'b0, 4'b0011,1'b0,1'b1,4'b0011,3'd0,1'b0,4'b0000});
    vecs.push_back('{1'b0,1'b0,1'b0,4'b0000,1'b0,1'b0,4'b0000,1'b0,1'b0,1'b0, 4'b0011,1'b0,1'b1,4'b0011,3'd0,1'b0,4'b0000});
    // Writeback with flush at count 0 is not an underflow
    vecs.push_back('{1'b0,1'b0,1'b0,4'b1110,1'b1,1'b1,4'b1111,1'b1,1'b0,1'b0, 4'b1111,1'b0,1'b1,4'b1111,3'd0,1'b0,4'b0000});
    // wb_valid without S bit leaves flags alone
    vecs.push_back('{1'b0,1'b0,1'b0,4'b1110,1'b1,1'b0,4'b0101,1'b0,1'b0,1'b0, 4'b1111,1'b0,1'b1,4'b1111,3'd0,1'b0,4'b0000});
`ifdef FLAG_SHADOW_EN
    // Save 1000, overwrite with 0001, restore beats a same-cycle write of 0110
    vecs.push_back('{1'b1,1'b0,1'b0,4'b1110,1'b1,1'b1,4'b1000,1'b0,1'b0,1'b0, 4'b1000,1'b0,1'b1,4'b1000,3'd0,1'b1,4'b0000});
    vecs.push_back('{1'b0,1'b0,1'b0,4'b1110,1'b0,1'b0,4'b0000,1'b0,1'b1,1'b0, 4'b1000,1'b0,1'b1,4'b1000,3'd0,1'b1,4'b1000});
    vecs.push_back('{1'b0,1'b0,1'b0,4'b1110,1'b1,1'b1,4'b0001,1'b0,1'b0,1'b0, 4'b0001,1'b0,1'b1,4'b0001,3'd0,1'b1,4'b1000});
    vecs.push_back('{1'b0,1'b0,1'b0,4'b1110,1'b1,1'b1,4'b0110,1'b0,1'b0,1'b1, 4'b1000,1'b0,1'b1,4'b1000,3'd0,1'b1,4'b1000});
`endif

    drive_idle();
    repeat (2) @(posedge clk);
    #1;
    foreach (vecs[i]) apply(i, vecs[i]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/flag_status_unit.md
Name: flag_status_unit

Overview:
- Producer side of the NZCV flag interface. Holds the architectural status register (N, Z, C, V) written by flag-setting instructions at writeback.
- Supplies forwarded flags to the decode-stage condition evaluator.
- Tracks in-flight flag writers and stalls any conditional instruction in decode until the flags it depends on are committed.

Parameters:
- MAX_PENDING, 3, maximum number of in-flight flag-setting instructions (1..7).
- CNT_W, 3, width of pending counter; must satisfy 2^CNT_W > MAX_PENDING.

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- issue_valid  input  1  instruction leaves decode this cycle
- issue_s  input  1  that instruction sets flags (S bit)
- cond_in  input  4  condition field of the instruction currently in decode
- wb_valid  input  1  instruction commits at writeback this cycle
- wb_s  input  1  committing instruction sets flags
- wb_flags  input  4  {N,Z,C,V} from the committing instruction
- flush  input  1  kill all in-flight instructions upstream of writeback
- flags_q  output  4  registered {N,Z,C,V}
- flags_fwd  output  4  bypassed flags for the condition evaluator
- pending_cnt  output  CNT_W  in-flight flag writers
- issue_ready  output  1  a flag-setting issue is accepted this cycle
- flag_stall  output  1  hold decode; flags are not yet valid
- err_sticky  output  1  overflow or underflow seen since reset

Behaviour:
- Reset (rst_n low, asynchronous): flags_q=0, pending_cnt=0, err_sticky=0.
- Derived outputs with reset values: issue_ready=1, flag_stall=0, flags_fwd=0.
- Terms:
  - wr = wb_valid & wb_s
  - inc = issue_valid & issue_s & issue_ready & ~flag_stall
  - dec = wr
- Flag write: if wr, flags_q <= wb_flags at the next edge.
- flags_fwd: wb_flags when wr, else flags_q. Combinational; zero added latency.
- needs_flags = (cond_in[3:1] != 3'b111). Codes 1110 and 1111 are unconditional.
- eff_cnt = pending_cnt - dec.
- flag_stall = needs_flags & (eff_cnt != 0). Combinational.
  - A writer committing in the same cycle counts as resolved and is read through flags_fwd.
- issue_ready = (eff_cnt < MAX_PENDING).
- Counter update, no flush:
  - pending_cnt <= pending_cnt + inc - dec.
  - inc and dec together leave it unchanged.
- Flush:
  - pending_cnt <= 0, and any inc this cycle is discarded.
  - A wr in the same cycle still updates flags_q; flush never blocks writeback.
- Overflow: issue_valid & issue_s & ~issue_ready sets err_sticky. The count is unchanged and the instruction is not counted.
- Underflow: dec with pending_cnt==0 and no flush sets err_sticky; the count stays 0.
  - After a flush, a wr of an older surviving instruction is legal only if it was counted. The pipeline guarantees this.
- err_sticky clears only on reset.
- Reset mid-operation: all state returns to reset values immediately. No pending writes are retained.

Optional Feature:
- Macro: FLAG_SHADOW_EN. Adds a one-entry shadow register for exception entry/return.
- With FLAG_SHADOW_EN:
  - Ports save_req (in 1), restore_req (in 1) and shadow_q (out 4) exist. Shadow resets to 0.
  - save_req: shadow_q <= flags_fwd.
  - restore_req: flags_q <= shadow_q. It takes priority over a same-cycle wr, and flags_fwd returns shadow_q that cycle.
  - save_req and restore_req together: restore wins for flags_q; shadow is loaded with the pre-restore flags_fwd.
- Without the macro: those ports and the shadow register are absent; behaviour is otherwise identical.

Test Plan:
- Reset, then wr with wb_flags=4'b0100 -> flags_fwd=0100 in the same cycle; flags_q=0100 next cycle; pending_cnt stays 0; err_sticky=1 (underflow).
- Issue S instruction, then cond_in=0000 (EQ) in decode -> flag_stall=1 while pending_cnt=1. On wr with 0100: flag_stall=0 that cycle, flags_fwd=0100, pending_cnt=0 next cycle.
- cond_in=1110 with pending_cnt=2 -> flag_stall=0.
- Three S issues with MAX_PENDING=3 -> pending_cnt=3, issue_ready=0. A fourth S issue -> err_sticky=1, count stays 3. Same cycle with a wr -> issue_ready=1 and count stays 3.
- pending_cnt=2, flush together with wr of 0011 -> pending_cnt=0, flags_q=0011, err_sticky=0.
- FLAG_SHADOW_EN: flags_q=1000, save_req; then wr 0001; then restore_req together with wr 0110 -> flags_q=1000.
